// File: rtl/imm_extend_unit.sv
// Immediate-extension stage: extends an IMM_WIDTH immediate to DATA_WIDTH by mode,
// then buffers the result behind a valid/ready handshake with a two-entry skid buffer.
module imm_extend_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IMM_WIDTH-1:0]  imm,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic [1:0]            out_mode,
  output logic [1:0]            state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // in_ready depends only on internal state, and out/out_mode hold while out_valid && !out_ready.

  localparam int EXT = DATA_WIDTH - IMM_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] sext_val;
  logic [DATA_WIDTH-1:0] zext_val;
  logic [DATA_WIDTH-1:0] upper_val;
  logic [DATA_WIDTH-1:0] branch_val;
  logic [DATA_WIDTH-1:0] ext_val;

  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [1:0]            main_mode_q, main_mode_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [1:0]            skid_mode_q, skid_mode_d;

  logic accept;

  // With equal widths every non-branch mode is a plain copy; a zero-width
  // replication is not legal, so that case gets its own branch.
  generate
    if (EXT == 0) begin : g_no_ext
      assign sext_val  = imm;
      assign zext_val  = imm;
      assign upper_val = imm;
    end else begin : g_ext
      assign sext_val  = {{EXT{imm[IMM_WIDTH-1]}}, imm};
      assign zext_val  = {{EXT{1'b0}}, imm};
      assign upper_val = {imm, {EXT{1'b0}}};
    end
  endgenerate

  assign branch_val = sext_val << 2;

  always_comb begin
    ext_val = sext_val;
    case (mode)
      2'b00:   ext_val = sext_val;
      2'b01:   ext_val = zext_val;
      2'b10:   ext_val = upper_val;
      default: ext_val = branch_val;
    endcase
  end

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign out       = main_data_q;
  assign out_mode  = main_mode_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_mode_q <= 2'b00;
      skid_data_q <= '0;
      skid_mode_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_mode_q <= main_mode_d;
      skid_data_q <= skid_data_d;
      skid_mode_q <= skid_mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_mode_d = main_mode_q;
    skid_data_d = skid_data_q;
    skid_mode_d = skid_mode_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_data_d = ext_val;
          main_mode_d = mode;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept && !out_ready) begin
          skid_data_d = ext_val;
          skid_mode_d = mode;
          state_d     = ST_FULL;
        end else if (accept && out_ready) begin
          main_data_d = ext_val;
          main_mode_d = mode;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so no new result can arrive on the same edge.
        if (out_ready) begin
          main_data_d = skid_data_q;
          main_mode_d = skid_mode_q;
          state_d     = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

endmodule
